// File: rtl/sdr_index_decoder.sv
// sdr_index_decoder
// Expands a packed list of 16-bit sparse indexes into a dense 32x32 SDR matrix.
// The list is walked one index per cycle after a rising edge on ctrl_i[0].
// ctrl_i[1] (keep) skips the clearing pass so new bits are OR-ed into the matrix.
// Optional feature: define SDR_IDX_ORDER_CHK_EN to flag indexes that are not
// strictly ascending in status_o[27]. When it is undefined, that bit is 0.
module sdr_index_decoder #(
  parameter int NumWords = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [31:0]                ctrl_i,
  input  logic [0:NumWords-1][31:0]  idx_i,
  output logic [0:31][31:0]          sdr_o,
  output logic [31:0]                status_o
);

  localparam int MaxIdx = 2 * NumWords;
  localparam int WordW  = (NumWords > 1) ? $clog2(NumWords) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SCAN  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  state_e      state_reg, state_next;
  logic        start_reg;
  logic        trigger;
  logic [7:0]  ones_reg;
  logic [7:0]  consumed_reg;
  logic        dup_reg;
  logic        order_err;
  logic [31:0] status_reg;
  logic [31:0] sdr_reg [32];

  // Decoded view of the index currently pointed to by the consumed count
  logic [WordW-1:0] word_sel;
  logic [31:0]      cur_word;
  logic [15:0]      cur_idx;
  logic [4:0]       cur_row;
  logic [4:0]       cur_pos;
  logic             is_term;
  logic             is_bad;
  logic             bit_set;
  logic             last_idx;

  // FSM strobes
  logic start_build;
  logic clear_en;
  logic set_en;
  logic busy;

  // Only start and keep are defined in the control word
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_i[31:2];

  assign trigger  = ctrl_i[0] & ~start_reg;
  assign word_sel = consumed_reg[WordW:1];
  assign cur_word = idx_i[word_sel];
  assign cur_idx  = consumed_reg[0] ? cur_word[31:16] : cur_word[15:0];
  assign cur_row  = cur_idx[9:5];
  assign cur_pos  = cur_idx[4:0];
  assign is_term  = (cur_idx == 16'hFFFF);
  assign is_bad   = !is_term && (cur_idx[15:10] != 6'd0);
  assign bit_set  = sdr_reg[cur_row][cur_pos];
  assign last_idx = (consumed_reg == 8'(MaxIdx - 1));

  // Start edge detector register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) start_reg <= 1'b0;
    else         start_reg <= ctrl_i[0];
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // FSM next-state logic; triggers while busy are ignored
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (trigger) state_next = ctrl_i[1] ? SCAN : CLEAR;
      end
      CLEAR: state_next = SCAN;
      SCAN: begin
        if (is_term)       state_next = DONE;
        else if (is_bad)   state_next = ERR;
        else if (last_idx) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output decode into datapath strobes
  always_comb begin
    start_build = 1'b0;
    clear_en    = 1'b0;
    set_en      = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      IDLE, DONE, ERR: start_build = trigger;
      CLEAR: begin
        clear_en = 1'b1;
        busy     = 1'b1;
      end
      SCAN: begin
        set_en = !is_term && !is_bad;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // Ones/consumed counters and duplicate flag, restarted on each accepted trigger
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_reg     <= 8'd0;
      consumed_reg <= 8'd0;
      dup_reg      <= 1'b0;
    end else if (start_build) begin
      ones_reg     <= 8'd0;
      consumed_reg <= 8'd0;
      dup_reg      <= 1'b0;
    end else if (set_en) begin
      consumed_reg <= consumed_reg + 8'd1;
      if (bit_set) dup_reg  <= 1'b1;
      else         ones_reg <= ones_reg + 8'd1;
    end
  end

  // One register per matrix row: cleared by CLEAR, single bit set on a valid index
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_row
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                               sdr_reg[gi] <= 32'd0;
        else if (clear_en)                         sdr_reg[gi] <= 32'd0;
        else if (set_en && (cur_row == 5'(gi)))    sdr_reg[gi][cur_pos] <= 1'b1;
      end
      assign sdr_o[gi] = sdr_reg[gi];
    end
  endgenerate

`ifdef SDR_IDX_ORDER_CHK_EN
  logic [9:0] prev_reg;
  logic       prev_valid_reg;
  logic       order_reg;

  // Remember the last valid {row,pos}; flag any index not strictly above it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_reg       <= 10'd0;
      prev_valid_reg <= 1'b0;
      order_reg      <= 1'b0;
    end else if (start_build) begin
      prev_reg       <= 10'd0;
      prev_valid_reg <= 1'b0;
      order_reg      <= 1'b0;
    end else if (set_en) begin
      if (prev_valid_reg && (cur_idx[9:0] <= prev_reg)) order_reg <= 1'b1;
      prev_reg       <= cur_idx[9:0];
      prev_valid_reg <= 1'b1;
    end
  end

  assign order_err = order_reg;
`else
  assign order_err = 1'b0;
`endif

  // Status word is registered, so it reflects the state one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_reg <= 32'd0;
    end else begin
      status_reg <= {(state_reg == DONE), (state_reg == ERR), busy, dup_reg,
                     order_err, 11'd0, ones_reg, consumed_reg};
    end
  end

  assign status_o = status_reg;

endmodule

// File: tb/tb_sdr_index_decoder.sv
// Directed testbench for sdr_index_decoder.
module tb_sdr_index_decoder;

  logic              clk;
  logic              rst_n;
  logic [31:0]       ctrl;
  logic [0:15][31:0] idx;
  logic [0:31][31:0] sdr;
  logic [31:0]       status;

  int vectors;
  int miscompares;
  int done_edge;
  logic [31:0] exp_rows [32];

  sdr_index_decoder #(.NumWords(16)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .ctrl_i   (ctrl),
    .idx_i    (idx),
    .sdr_o    (sdr),
    .status_o (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
  endtask

  // Compares every row against exp_rows, one comparison per row
  task automatic check_rows(input string tag);
    for (int r = 0; r < 32; r++) begin
      vectors++;
      assert (sdr[r] === exp_rows[r]) else begin
        miscompares++;
        $error("FAIL %s row %0d observed=%h expected=%h", tag, r, sdr[r], exp_rows[r]);
      end
    end
    $display("vec %0d %s rows checked", vectors, tag);
  endtask

  task automatic clear_exp();
    for (int r = 0; r < 32; r++) exp_rows[r] = 32'd0;
  endtask

  task automatic fill_idx_term();
    for (int w = 0; w < 16; w++) idx[w] = 32'hFFFF_FFFF;
  endtask

  // Raises start before edge 0 and returns the first edge (>=1) at which
  // done or error is visible in the status word; -1 if the bound expires.
  // pulse_at >= 0 re-pulses start after that edge to test a busy-time trigger.
  task automatic run_build(input logic keep, input int pulse_at, output int edge_no);
    edge_no = -1;
    @(negedge clk);
    ctrl = {30'd0, keep, 1'b1};
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) ctrl[0] = 1'b0;
      if (pulse_at >= 0 && i == pulse_at) ctrl[0] = 1'b1;
      if (pulse_at >= 0 && i == pulse_at + 1) ctrl[0] = 1'b0;
      if (i >= 1 && (status[31] || status[30])) begin
        edge_no = i;
        break;
      end
    end
    ctrl[0] = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    ctrl  = 32'd0;
    fill_idx_term();
    clear_exp();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_rows("reset_sdr");
    check32("reset_status", status, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check32("idle_status", status, 32'h0000_0000);

    // Three valid indexes then terminator
    fill_idx_term();
    idx[0] = 32'h0021_0000;
    idx[1] = 32'hFFFF_03FF;
    run_build(1'b0, -1, done_edge);
    check_int("basic_done_edge", done_edge, 6);
    check32("basic_status", status, 32'h8000_0303);
    clear_exp();
    exp_rows[0] = 32'h0000_0001;
    exp_rows[1] = 32'h0000_0002;
    exp_rows[31] = 32'h8000_0000;
    check_rows("basic_sdr");

    // Full diagonal list without terminator
    for (int w = 0; w < 16; w++) begin
      idx[w][15:0]  = 16'((2 * w) * 33);
      idx[w][31:16] = 16'((2 * w + 1) * 33);
    end
    run_build(1'b0, -1, done_edge);
    check_int("diag_done_edge", done_edge, 34);
    check32("diag_status", status, 32'h8000_2020);
    for (int r = 0; r < 32; r++) exp_rows[r] = 32'd1 << r;
    check_rows("diag_sdr");

    // Duplicate index
    fill_idx_term();
    idx[0] = 32'h0005_0005;
    run_build(1'b0, -1, done_edge);
    check_int("dup_done_edge", done_edge, 5);
`ifdef SDR_IDX_ORDER_CHK_EN
    check32("dup_status", status, 32'h9800_0102);
`else
    check32("dup_status", status, 32'h9000_0102);
`endif
    clear_exp();
    exp_rows[0] = 32'h0000_0020;
    check_rows("dup_sdr");

    // Malformed second index
    fill_idx_term();
    idx[0] = 32'h0400_0001;
    run_build(1'b0, -1, done_edge);
    check_int("err_edge", done_edge, 4);
    check32("err_status", status, 32'h4000_0101);
    clear_exp();
    exp_rows[0] = 32'h0000_0002;
    check_rows("err_sdr");

    // Recovery from ERR with a valid list
    fill_idx_term();
    idx[0] = 32'h0001_0000;
    run_build(1'b0, -1, done_edge);
    check_int("recover_done_edge", done_edge, 5);
    check32("recover_status", status, 32'h8000_0202);
    clear_exp();
    exp_rows[0] = 32'h0000_0003;
    check_rows("recover_sdr");

    // Keep: one already-set bit and one new bit over the existing matrix
    fill_idx_term();
    idx[0] = 32'h0022_0001;
    run_build(1'b1, -1, done_edge);
    check_int("keep_done_edge", done_edge, 4);
    check32("keep_status", status, 32'h9000_0102);
    exp_rows[0] = 32'h0000_0003;
    exp_rows[1] = 32'h0000_0004;
    check_rows("keep_sdr");

    // Start pulse mid-SCAN must be ignored
    for (int w = 0; w < 16; w++) begin
      idx[w][15:0]  = 16'((2 * w) * 33);
      idx[w][31:16] = 16'((2 * w + 1) * 33);
    end
    run_build(1'b0, 10, done_edge);
    check_int("midtrig_done_edge", done_edge, 34);
    check32("midtrig_status", status, 32'h8000_2020);

    // Reset mid-SCAN clears everything immediately
    @(negedge clk);
    ctrl = 32'h0000_0001;
    repeat (9) @(posedge clk);
    #1;
    ctrl = 32'd0;
    check32("midscan_status", status, 32'h2000_0606);
    rst_n = 1'b0;
    #1;
    check32("midreset_status", status, 32'h0000_0000);
    clear_exp();
    check_rows("midreset_sdr");
    @(negedge clk);
    rst_n = 1'b1;

    // Block works normally after the reset
    fill_idx_term();
    idx[0] = 32'h0021_0000;
    idx[1] = 32'hFFFF_03FF;
    run_build(1'b1, -1, done_edge);
    check_int("post_reset_done_edge", done_edge, 5);
    check32("post_reset_status", status, 32'h8000_0303);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
